// File: rtl/program_loader.sv
// Streams program words into instruction memory at consecutive addresses and holds the CPU
// in reset until the last word is written. Write latency 1 cycle; in_ready decoded from state.
module program_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [ADDR_WIDTH-1:0]   count_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic                    cpu_hold_q;

  logic                    accept;
  logic                    last_word;
  logic [ADDR_WIDTH-1:0]   wr_addr_d;

  assign accept    = in_valid && (state_q == S_LOAD);
  assign last_word = (count_q == (len_q - ADDR_ONE));
  assign wr_addr_d = base_q + count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cpu_hold_q <= 1'b1;
            count_q    <= '0;
            if (length == ADDR_ZERO) begin
              state_q <= S_DONE;
            end else begin
              base_q  <= base_addr;
              len_q   <= length;
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wr_addr_d;
            mem_wdata_q <= in_data;
            count_q     <= count_q + ADDR_ONE;
            if (last_word) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // The final write is already on the memory port this cycle, so release is safe next.
          cpu_hold_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed per-cycle vector table for program_loader plus a hand-run start-during-load sequence.
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;

  int n_vec;
  int n_err;

  typedef struct {
    logic        rst;
    logic        start;
    logic [15:0] base;
    logic [15:0] len;
    logic        vld;
    logic [15:0] data;
    logic        rdy;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
    logic        hold;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t tbl[$];

  program_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic s, input logic [15:0] b, input logic [15:0] l,
                     input logic v, input logic [15:0] d,
                     input logic rdy, input logic we, input logic [15:0] a, input logic [15:0] wd,
                     input logic h, input logic bs, input logic dn);
    vec_t t;
    t.rst = r; t.start = s; t.base = b; t.len = l; t.vld = v; t.data = d;
    t.rdy = rdy; t.we = we; t.addr = a; t.wd = wd; t.hold = h; t.bsy = bs; t.dn = dn;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic r, input logic s, input logic [15:0] b, input logic [15:0] l,
                       input logic v, input logic [15:0] d);
    @(negedge clk);
    rst = r; start = s; base_addr = b; length = l; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [36:0] got, input logic [36:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy/we/addr/wdata/hold/busy/done=%b/%b/%h/%h/%b/%b/%b required %b/%b/%h/%h/%b/%b/%b",
               name, got[36], got[35], got[34:19], got[18:3], got[2], got[1], got[0],
               exp[36], exp[35], exp[34:19], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0; in_data = '0;

    //   rst start base     len      vld data       rdy we addr     wdata    hold busy done
    // reset
    add(1, 0, 16'h0000, 16'd0, 0, 16'h0000,   0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(1, 0, 16'h0000, 16'd0, 0, 16'h0000,   0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 0, 16'h0000, 16'd0, 0, 16'h0000,   0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    // base 0, len 4, valid held high (not accepted while still in IDLE)
    add(0, 1, 16'h0000, 16'd4, 1, 16'hA001,   1, 0, 16'h0000, 16'h0000, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hA001,   1, 1, 16'h0000, 16'hA001, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hA002,   1, 1, 16'h0001, 16'hA002, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hA003,   1, 1, 16'h0002, 16'hA003, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hA004,   0, 1, 16'h0003, 16'hA004, 1, 1, 1);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hA005,   0, 0, 16'h0003, 16'hA004, 0, 0, 0);
    add(0, 0, 16'h0000, 16'd0, 0, 16'h0000,   0, 0, 16'h0003, 16'hA004, 0, 0, 0);
    // len 3 with gaps in valid; start re-asserts hold
    add(0, 1, 16'h0100, 16'd3, 0, 16'h0000,   1, 0, 16'h0003, 16'hA004, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hB001,   1, 1, 16'h0100, 16'hB001, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 0, 16'hDEAD,   1, 0, 16'h0100, 16'hB001, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 0, 16'hDEAD,   1, 0, 16'h0100, 16'hB001, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hB002,   1, 1, 16'h0101, 16'hB002, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 0, 16'hDEAD,   1, 0, 16'h0101, 16'hB002, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hB003,   0, 1, 16'h0102, 16'hB003, 1, 1, 1);
    add(0, 0, 16'h0000, 16'd0, 0, 16'h0000,   0, 0, 16'h0102, 16'hB003, 0, 0, 0);
    // address wrap from 0xFFFE
    add(0, 1, 16'hFFFE, 16'd4, 0, 16'h0000,   1, 0, 16'h0102, 16'hB003, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hC001,   1, 1, 16'hFFFE, 16'hC001, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hC002,   1, 1, 16'hFFFF, 16'hC002, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hC003,   1, 1, 16'h0000, 16'hC003, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hC004,   0, 1, 16'h0001, 16'hC004, 1, 1, 1);
    add(0, 0, 16'h0000, 16'd0, 0, 16'h0000,   0, 0, 16'h0001, 16'hC004, 0, 0, 0);
    // zero-length load: no write, done right after start
    add(0, 1, 16'h1234, 16'd0, 1, 16'hEEEE,   0, 0, 16'h0001, 16'hC004, 1, 1, 1);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hEEEE,   0, 0, 16'h0001, 16'hC004, 0, 0, 0);
    // reset after 2 of 5 words
    add(0, 1, 16'h0200, 16'd5, 0, 16'h0000,   1, 0, 16'h0001, 16'hC004, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hD001,   1, 1, 16'h0200, 16'hD001, 1, 1, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hD002,   1, 1, 16'h0201, 16'hD002, 1, 1, 0);
    add(1, 0, 16'h0000, 16'd0, 1, 16'hD003,   0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hD004,   0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 0, 16'h0000, 16'd0, 1, 16'hD005,   0, 0, 16'h0000, 16'h0000, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].base, tbl[i].len, tbl[i].vld, tbl[i].data);
      check($sformatf("vec%0d", i),
            {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done},
            {tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].hold, tbl[i].bsy, tbl[i].dn});
    end

    // start held high with a different base/length while loading must not disturb the load
    begin
      int          n_wr;
      int          n_done;
      logic [15:0] wa [2];
      logic [15:0] wdat [2];
      n_wr   = 0;
      n_done = 0;
      drive(0, 1, 16'h0300, 16'd2, 0, 16'h0000);
      drive(0, 1, 16'h0400, 16'd7, 1, 16'hE001);
      if (mem_we) begin if (n_wr < 2) begin wa[n_wr] = mem_addr; wdat[n_wr] = mem_wdata; end n_wr++; end
      if (done) n_done++;
      drive(0, 1, 16'h0400, 16'd7, 1, 16'hE002);
      if (mem_we) begin if (n_wr < 2) begin wa[n_wr] = mem_addr; wdat[n_wr] = mem_wdata; end n_wr++; end
      if (done) n_done++;
      for (int k = 0; k < 5; k++) begin
        drive(0, 0, 16'h0000, 16'd0, 1, 16'hE0F0 + 16'(k));
        if (mem_we) begin if (n_wr < 2) begin wa[n_wr] = mem_addr; wdat[n_wr] = mem_wdata; end n_wr++; end
        if (done) n_done++;
      end
      check_val("ign_start_writes", n_wr, 2);
      check_val("ign_start_done_pulses", n_done, 1);
      if (n_wr >= 2) begin
        check_val("ign_start_addr0", int'(wa[0]), 32'h0300);
        check_val("ign_start_addr1", int'(wa[1]), 32'h0301);
        check_val("ign_start_data0", int'(wdat[0]), 32'hE001);
        check_val("ign_start_data1", int'(wdat[1]), 32'hE002);
      end
      check_val("ign_start_hold_released", int'(cpu_hold), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
